i2c_slave_regs: RTL and testbench

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

---
 rtl/i2c_slave_regs.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// i2c_slave_regs
//
// I2C slave that exposes a small file of 8-bit registers to a bus master.
// A write transaction carries a register pointer byte followed by any number
// of data bytes, which land in consecutive registers. A read transaction
// streams registers out starting at the current pointer. The pointer
// auto-increments and wraps modulo NREGS. It is kept across transactions.
// The local side sees every bus write as a strobe. It can also read any
// register combinationally.
//
// Parameters
//   SLAVE_ADDR : 7-bit bus address this block answers to
//   NREGS      : number of registers (power of two, 2..256)
//
// Ports
//   clk     in   system clock, at least 8x the SCL rate
//   resetn  in   asynchronous active-low reset
//   scl_i   in   raw SCL from the bus (asynchronous to clk)
//   sda_i   in   raw SDA from the bus (asynchronous to clk)
//   sda_oe  out  1 = pull SDA low, 0 = release (open drain)
//   busy    out  high from address match until STOP, START or mismatch
//   wr_stb  out  one-clk pulse per register written from the bus
//   wr_addr out  index of the last register written (valid with wr_stb)
//   wr_data out  data of the last register written (valid with wr_stb)
//   rd_addr in   local read index
//   rd_data out  register contents at rd_addr (combinational)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NREGS      = 16,
  localparam int        PW         = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_stb,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [PW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ptrPending_q, ptrPending_d;
  logic          sdaOe_q, sdaOe_d;
  logic          busy_q, busy_d;
  logic          wrStb_q, wrStb_d;
  logic [PW-1:0] wrAddr_q, wrAddr_d;
  logic [7:0]    wrData_q, wrData_d;

  logic          sclMeta_q, sclSync_q, sclDly_q;
  logic          sdaMeta_q, sdaSync_q, sdaDly_q;

  logic [7:0]    regs_q [NREGS];
  logic          regWe;

  logic          sclRise, sclFall, startDet, stopDet;
  logic [7:0]    newByte;
  logic [PW-1:0] ptrInc;
  logic [7:0]    curRegByte, nextRegByte;

  // Two-flop synchronizers plus a delay flop so that edges can be seen on
  // clean signals. They reset to 1 because an idle bus is high on both lines.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclDly_q  <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaDly_q  <= 1'b1;
    end else begin
      sclMeta_q <= scl_i;
      sclSync_q <= sclMeta_q;
      sclDly_q  <= sclSync_q;
      sdaMeta_q <= sda_i;
      sdaSync_q <= sdaMeta_q;
      sdaDly_q  <= sdaSync_q;
    end
  end

  // START and STOP are SDA edges while SCL is stable high. Data edges only
  // happen while SCL is low, so these can never collide with a bit sample.
  assign sclRise  = sclSync_q & ~sclDly_q;
  assign sclFall  = ~sclSync_q & sclDly_q;
  assign startDet = sclSync_q & sclDly_q & sdaDly_q & ~sdaSync_q;
  assign stopDet  = sclSync_q & sclDly_q & ~sdaDly_q & sdaSync_q;

  assign newByte     = {shift_q[6:0], sdaSync_q};
  assign ptrInc      = ptr_q + PW'(1);
  assign curRegByte  = regs_q[ptr_q];
  assign nextRegByte = regs_q[ptrInc];

  // Protocol state and all bus-side registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      ptr_q        <= '0;
      ptrPending_q <= 1'b0;
      sdaOe_q      <= 1'b0;
      busy_q       <= 1'b0;
      wrStb_q      <= 1'b0;
      wrAddr_q     <= '0;
      wrData_q     <= '0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      ptrPending_q <= ptrPending_d;
      sdaOe_q      <= sdaOe_d;
      busy_q       <= busy_d;
      wrStb_q      <= wrStb_d;
      wrAddr_q     <= wrAddr_d;
      wrData_q     <= wrData_d;
    end
  end

  // Register file. Bus writes always target the current pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (regWe) begin
      regs_q[ptr_q] <= newByte;
    end
  end

  // Next-state logic. START and STOP override whatever the FSM is doing.
  // Slave-driven SDA changes only on SCL falls, so the master always sees
  // stable data while SCL is high. The ACK slot is opened on the fall after
  // the 8th bit and closed on the fall after the 9th.
  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    ptr_d        = ptr_q;
    ptrPending_d = ptrPending_q;
    sdaOe_d      = sdaOe_q;
    busy_d       = busy_q;
    wrStb_d      = 1'b0;
    wrAddr_d     = wrAddr_q;
    wrData_d     = wrData_q;
    regWe        = 1'b0;

    if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = '0;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
    end else if (stopDet) begin
      state_d = IDLE;
      sdaOe_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end

        ADDR: begin
          if (sclRise && bitCnt_q < 4'd8) begin
            shift_d  = newByte;
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall && bitCnt_q == 4'd8) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              sdaOe_d = 1'b1;
              busy_d  = 1'b1;
              state_d = ADDR_ACK;
            end else begin
              sdaOe_d = 1'b0;
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end
        end

        // The shifter still holds the address byte; bit 0 is R/W.
        ADDR_ACK: begin
          if (sclFall) begin
            bitCnt_d = '0;
            if (shift_q[0]) begin
              shift_d = curRegByte;
              sdaOe_d = ~curRegByte[7];
              state_d = RD_BYTE;
            end else begin
              sdaOe_d      = 1'b0;
              ptrPending_d = 1'b1;
              state_d      = WR_BYTE;
            end
          end
        end

        // The first byte of a write sets the pointer; later bytes are data.
        WR_BYTE: begin
          if (sclRise && bitCnt_q < 4'd8) begin
            shift_d  = newByte;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              if (ptrPending_q) begin
                ptr_d        = newByte[PW-1:0];
                ptrPending_d = 1'b0;
              end else begin
                regWe    = 1'b1;
                wrStb_d  = 1'b1;
                wrAddr_d = ptr_q;
                wrData_d = newByte;
                ptr_d    = ptrInc;
              end
            end
          end else if (sclFall && bitCnt_q == 4'd8) begin
            sdaOe_d = 1'b1;
            state_d = WR_ACK;
          end
        end

        WR_ACK: begin
          if (sclFall) begin
            sdaOe_d  = 1'b0;
            bitCnt_d = '0;
            state_d  = WR_BYTE;
          end
        end

        // Bit 7 is already on the wire when this state is entered. Each
        // fall presents the next bit; the 8th fall hands SDA to the master.
        RD_BYTE: begin
          if (sclFall) begin
            if (bitCnt_q == 4'd7) begin
              sdaOe_d  = 1'b0;
              bitCnt_d = '0;
              state_d  = RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sdaOe_d  = ~shift_q[6];
              bitCnt_d = bitCnt_q + 4'd1;
            end
          end
        end

        // Entered on a fall, so the next rise is the master's ACK bit.
        // After an ACK the only further event here is the fall that
        // starts the next byte.
        RD_ACK: begin
          if (sclRise) begin
            if (!sdaSync_q) begin
              ptr_d   = ptrInc;
              shift_d = nextRegByte;
            end else begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end else if (sclFall) begin
            sdaOe_d  = ~shift_q[7];
            bitCnt_d = '0;
            state_d  = RD_BYTE;
          end
        end

        IGNORE: begin
          sdaOe_d = 1'b0;
          busy_d  = 1'b0;
        end

        default: begin
          state_d = IDLE;
          sdaOe_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe  = sdaOe_q;
  assign busy    = busy_q;
  assign wr_stb  = wrStb_q;
  assign wr_addr = wrAddr_q;
  assign wr_data = wrData_q;
  assign rd_data = regs_q[rd_addr];

endmodule

// File: tb/tb_i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regs
//
// Directed testbench for i2c_slave_regs. It acts as a bit-banged I2C master
// on an open-drain SDA line and replays hand-written transactions. Results
// are compared against hand-computed expectations: ACK bits, read data,
// the wr_stb log, busy, and the local register view.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2c_slave_regs;

  localparam time Q = 100ns;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sclM = 1'b1;
  logic       sdaM = 1'b1;
  logic       sdaOe;
  logic       busy;
  logic       wrStb;
  logic [3:0] wrAddr;
  logic [7:0] wrData;
  logic [3:0] rdAddr = 4'd0;
  logic [7:0] rdData;
  logic       sdaLine;

  int vecCount  = 0;
  int missCount = 0;
  int stbAddrLog[$];
  int stbDataLog[$];

  assign sdaLine = sdaM & ~sdaOe;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .NREGS(16)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .scl_i   (sclM),
    .sda_i   (sdaLine),
    .sda_oe  (sdaOe),
    .busy    (busy),
    .wr_stb  (wrStb),
    .wr_addr (wrAddr),
    .wr_data (wrData),
    .rd_addr (rdAddr),
    .rd_data (rdData)
  );

  // 100 MHz system clock; SCL runs at clk/40.
  always #5 clk = ~clk;

  // Record every write strobe seen by the local side.
  always @(negedge clk) begin
    if (wrStb) begin
      stbAddrLog.push_back(int'(wrAddr));
      stbDataLog.push_back(int'(wrData));
    end
  end

  // Count a comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int logAddr(input int i);
    return (i < stbAddrLog.size()) ? stbAddrLog[i] : -1;
  endfunction

  function automatic int logData(input int i);
    return (i < stbDataLog.size()) ? stbDataLog[i] : -1;
  endfunction

  task automatic checkReg(input string tag, input int idx, input logic [7:0] expected);
    rdAddr = 4'(idx);
    #1;
    checkOutput(tag, 32'(rdData), 32'(expected));
  endtask

  task automatic busStart();
    sdaM = 1'b1; #Q;
    sclM = 1'b1; #Q;
    sdaM = 1'b0; #Q;
    sclM = 1'b0; #Q;
  endtask

  task automatic busStop();
    sdaM = 1'b0; #Q;
    sclM = 1'b1; #Q;
    sdaM = 1'b1; #Q;
  endtask

  task automatic sendBit(input logic b);
    sdaM = b; #Q;
    sclM = 1'b1; #(2*Q);
    sclM = 1'b0; #Q;
  endtask

  // Ninth clock with SDA released; returns 1 when the slave pulled it low.
  task automatic ackSlot(output logic ack);
    sdaM = 1'b1; #Q;
    sclM = 1'b1; #Q;
    ack = ~sdaLine; #Q;
    sclM = 1'b0; #Q;
  endtask

  // Master write of one byte, MSB first, followed by the slave ACK slot.
  task automatic applyStimulus(input logic [7:0] value, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sendBit(value[i]);
    end
    ackSlot(ack);
  endtask

  // Master read of one byte; masterAck=0 acknowledges, 1 NACKs.
  task automatic readByte(input logic masterAck, output logic [7:0] value);
    sdaM  = 1'b1;
    value = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #Q;
      sclM = 1'b1; #Q;
      value = {value[6:0], sdaLine}; #Q;
      sclM = 1'b0;
    end
    sdaM = masterAck; #Q;
    sclM = 1'b1; #(2*Q);
    sclM = 1'b0; #Q;
    sdaM = 1'b1;
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         base;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rstSdaOe", 32'(sdaOe), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstWrStb", 32'(wrStb), 0);
    checkOutput("rstWrAddr", 32'(wrAddr), 0);
    checkOutput("rstWrData", 32'(wrData), 0);
    checkReg("rstReg0", 0, 8'h00);
    @(negedge clk) resetn = 1'b1;
    repeat (10) @(posedge clk);

    // Pointer 3 then two data bytes
    $display("[TB] write 0x11,0x22 at pointer 3");
    busStart();
    applyStimulus(8'hA0, ack); checkOutput("w1AddrAck", 32'(ack), 1);
    checkOutput("w1Busy", 32'(busy), 1);
    applyStimulus(8'h03, ack); checkOutput("w1PtrAck", 32'(ack), 1);
    applyStimulus(8'h11, ack); checkOutput("w1D0Ack", 32'(ack), 1);
    applyStimulus(8'h22, ack); checkOutput("w1D1Ack", 32'(ack), 1);
    busStop();
    checkOutput("w1BusyStop", 32'(busy), 0);
    checkOutput("w1StbCount", 32'(stbAddrLog.size()), 2);
    checkOutput("w1Stb0Addr", 32'(logAddr(0)), 3);
    checkOutput("w1Stb0Data", 32'(logData(0)), 32'h11);
    checkOutput("w1Stb1Addr", 32'(logAddr(1)), 4);
    checkOutput("w1Stb1Data", 32'(logData(1)), 32'h22);
    checkReg("w1Reg3", 3, 8'h11);
    checkReg("w1Reg4", 4, 8'h22);

    // Set pointer, repeated START, read two bytes
    $display("[TB] read two bytes from pointer 3");
    base = stbAddrLog.size();
    busStart();
    applyStimulus(8'hA0, ack); checkOutput("r1AddrAck", 32'(ack), 1);
    applyStimulus(8'h03, ack); checkOutput("r1PtrAck", 32'(ack), 1);
    busStart();
    applyStimulus(8'hA1, ack); checkOutput("r1RdAddrAck", 32'(ack), 1);
    readByte(1'b0, rd); checkOutput("r1Byte0", 32'(rd), 32'h11);
    readByte(1'b1, rd); checkOutput("r1Byte1", 32'(rd), 32'h22);
    checkOutput("r1BusyNack", 32'(busy), 0);
    busStop();
    checkOutput("r1NoStb", 32'(stbAddrLog.size()), 32'(base));

    // Wrong address is ignored until STOP
    $display("[TB] address 0x51 is not acknowledged");
    busStart();
    applyStimulus(8'hA2, ack); checkOutput("mmAddrAck", 32'(ack), 0);
    checkOutput("mmBusy", 32'(busy), 0);
    applyStimulus(8'h55, ack); checkOutput("mmDataAck", 32'(ack), 0);
    busStop();
    checkOutput("mmNoStb", 32'(stbAddrLog.size()), 32'(base));
    checkReg("mmReg3", 3, 8'h11);

    // Pointer wrap from 15 to 0
    $display("[TB] write across the pointer wrap");
    base = stbAddrLog.size();
    busStart();
    applyStimulus(8'hA0, ack); checkOutput("wrAddrAck", 32'(ack), 1);
    applyStimulus(8'h0F, ack); checkOutput("wrPtrAck", 32'(ack), 1);
    applyStimulus(8'hAA, ack); checkOutput("wrD0Ack", 32'(ack), 1);
    applyStimulus(8'hBB, ack); checkOutput("wrD1Ack", 32'(ack), 1);
    busStop();
    checkOutput("wrStbCount", 32'(stbAddrLog.size()), 32'(base + 2));
    checkOutput("wrStb0Addr", 32'(logAddr(base)), 15);
    checkOutput("wrStb0Data", 32'(logData(base)), 32'hAA);
    checkOutput("wrStb1Addr", 32'(logAddr(base + 1)), 0);
    checkOutput("wrStb1Data", 32'(logData(base + 1)), 32'hBB);
    checkReg("wrReg15", 15, 8'hAA);
    checkReg("wrReg0", 0, 8'hBB);

    // Reset during data bit 4 of a write; SDA is high during that bit, so
    // releasing reset with SCL high cannot look like a START.
    $display("[TB] reset in the middle of a write byte");
    base = stbAddrLog.size();
    busStart();
    applyStimulus(8'hA0, ack); checkOutput("mrAddrAck", 32'(ack), 1);
    applyStimulus(8'h02, ack); checkOutput("mrPtrAck", 32'(ack), 1);
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    sdaM = 1'b1; #Q;
    sclM = 1'b1; #Q;
    resetn = 1'b0;
    #1;
    checkOutput("mrSdaOe", 32'(sdaOe), 0);
    checkOutput("mrBusy", 32'(busy), 0);
    checkReg("mrReg15", 15, 8'h00);
    checkReg("mrReg3", 3, 8'h00);
    #(Q/2);
    resetn = 1'b1;
    #(Q/2);
    sclM = 1'b0; #Q;
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b1); sendBit(1'b1);
    ackSlot(ack); checkOutput("mrTailAck", 32'(ack), 0);
    applyStimulus(8'h99, ack); checkOutput("mrNextAck", 32'(ack), 0);
    checkOutput("mrNoStb", 32'(stbAddrLog.size()), 32'(base));
    busStart();
    applyStimulus(8'hA0, ack); checkOutput("mrFreshAck", 32'(ack), 1);
    applyStimulus(8'h05, ack); checkOutput("mrFreshPtr", 32'(ack), 1);
    applyStimulus(8'h3C, ack); checkOutput("mrFreshData", 32'(ack), 1);
    busStop();
    checkOutput("mrStbAddr", 32'(logAddr(base)), 5);
    checkOutput("mrStbData", 32'(logData(base)), 32'h3C);
    checkReg("mrReg5", 5, 8'h3C);
    checkReg("mrReg4", 4, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
